// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit framer: serialises a byte as start, 8 data bits LSB-first, optional parity, 1-2 stop bits.
// Latency: start bit appears on TX_OUT the cycle after the Load_Pulse cycle; frame is 1+8+PAR_EN+STOP_BITS cycles.
// Backpressure: requests are accepted only in IDLE or on the final stop bit; Data_Valid is ignored otherwise.
module uart_tx_frame_ctrl #(
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] P_DATA,
  input  logic       Data_Valid,
  input  logic       PAR_EN,
  input  logic       PAR_bit,
  output logic       Load_Pulse,
  output logic       TX_OUT,
  output logic       Busy
);

  // Only one or two stop bits can be framed; anything else is a configuration error.
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_frame_ctrl: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       par_en_q;
  logic       stop_cnt;
  logic       final_stop;
  logic       can_accept;

  // Index of the last stop bit: 0 for one stop bit, 1 for two.
  localparam logic LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  // Accept window: idle, or the last stop bit is already on the line so the next start can follow directly.
  always_comb begin
    final_stop = (stop_cnt == LAST_STOP);
    can_accept = (state == IDLE) || ((state == STOP) && final_stop);
    Load_Pulse = Data_Valid && can_accept && !reset;
  end

  // Frame sequencer: state, shift register and the registered line/busy outputs all move on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      TX_OUT   <= 1'b1;
      Busy     <= 1'b0;
      shreg    <= 8'h00;
      bit_cnt  <= 3'd0;
      par_en_q <= 1'b0;
      stop_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Load_Pulse) begin
            shreg    <= P_DATA;
            par_en_q <= PAR_EN;
            state    <= START;
            TX_OUT   <= 1'b0;
            Busy     <= 1'b1;
          end else begin
            TX_OUT <= 1'b1;
            Busy   <= 1'b0;
          end
        end

        START: begin
          // First data bit goes out next; shift so shreg[0] is always the following bit.
          state   <= DATA;
          TX_OUT  <= shreg[0];
          shreg   <= {1'b0, shreg[7:1]};
          bit_cnt <= 3'd0;
          Busy    <= 1'b1;
        end

        DATA: begin
          Busy <= 1'b1;
          if (bit_cnt == 3'd7) begin
            bit_cnt <= 3'd0;
            if (par_en_q) begin
              // Parity stage registered PAR_bit at accept time, so it is stable here.
              state  <= PARITY;
              TX_OUT <= PAR_bit;
            end else begin
              state    <= STOP;
              TX_OUT   <= 1'b1;
              stop_cnt <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            TX_OUT  <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
          end
        end

        PARITY: begin
          state    <= STOP;
          TX_OUT   <= 1'b1;
          stop_cnt <= 1'b0;
          Busy     <= 1'b1;
        end

        STOP: begin
          if (final_stop) begin
            stop_cnt <= 1'b0;
            if (Load_Pulse) begin
              // Back-to-back frame: start bit directly after the last stop bit.
              shreg    <= P_DATA;
              par_en_q <= PAR_EN;
              state    <= START;
              TX_OUT   <= 1'b0;
              Busy     <= 1'b1;
            end else begin
              state  <= IDLE;
              TX_OUT <= 1'b1;
              Busy   <= 1'b0;
            end
          end else begin
            stop_cnt <= stop_cnt + 1'b1;
            TX_OUT   <= 1'b1;
            Busy     <= 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: one instance with one stop bit, one with two, sharing stimulus.
// Reference model keeps the list of line bits still owed for the current frame per instance.
// Directed scenarios first, then randomized requests, parity enables and occasional resets.
module tb_uart_tx_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_bit1 = 1'b0;
  logic       par_bit2 = 1'b0;
  logic       lp1, lp2, tx1, tx2, busy1, busy2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Bits remaining in the current frame (element 0 is the bit on the line now).
  logic mq [0:1][0:15];
  int   mlen [0:1];
  int   sbits [0:1];
  logic exp_ld [0:1];

  logic [15:0] hist_tx1, hist_busy1;
  int lp2_prev, lp2_last;

  always #5 clk = ~clk;

  uart_tx_frame_ctrl #(.STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .P_DATA(p_data), .Data_Valid(data_valid),
    .PAR_EN(par_en), .PAR_bit(par_bit1), .Load_Pulse(lp1), .TX_OUT(tx1), .Busy(busy1)
  );

  uart_tx_frame_ctrl #(.STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .P_DATA(p_data), .Data_Valid(data_valid),
    .PAR_EN(par_en), .PAR_bit(par_bit2), .Load_Pulse(lp2), .TX_OUT(tx2), .Busy(busy2)
  );

  // Parity calculator stand-in: even parity registered on the accept edge.
  always @(posedge clk) begin
    if (lp1) par_bit1 <= ^p_data;
    if (lp2) par_bit2 <= ^p_data;
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic exp_tx(input int k);
    return (mlen[k] > 0) ? mq[k][0] : 1'b1;
  endfunction

  task automatic push_bit(input int k, input logic b);
    mq[k][mlen[k]] = b;
    mlen[k]++;
  endtask

  task automatic model_step(input int k, input logic r, input logic [7:0] d, input logic pe);
    if (r) begin
      mlen[k] = 0;
    end else begin
      if (mlen[k] > 0) begin
        for (int i = 0; i < 15; i++) mq[k][i] = mq[k][i+1];
        mlen[k]--;
      end
      if (exp_ld[k]) begin
        push_bit(k, 1'b0);
        for (int i = 0; i < 8; i++) push_bit(k, d[i]);
        if (pe) push_bit(k, ^d);
        for (int i = 0; i < sbits[k]; i++) push_bit(k, 1'b1);
      end
    end
  endtask

  // One clock cycle: check registered outputs, apply inputs, check the strobe, advance model.
  task automatic cycle(input logic r, input logic v, input logic [7:0] d, input logic pe);
    hist_tx1   = {hist_tx1[14:0], tx1};
    hist_busy1 = {hist_busy1[14:0], busy1};
    check_eq("tx1", {15'd0, tx1}, {15'd0, exp_tx(0)});
    check_eq("tx2", {15'd0, tx2}, {15'd0, exp_tx(1)});
    check_eq("busy1", {15'd0, busy1}, {15'd0, (mlen[0] > 0)});
    check_eq("busy2", {15'd0, busy2}, {15'd0, (mlen[1] > 0)});
    reset = r; data_valid = v; p_data = d; par_en = pe;
    #1;
    for (int k = 0; k < 2; k++) exp_ld[k] = v && !r && (mlen[k] <= 1);
    check_eq("load1", {15'd0, lp1}, {15'd0, exp_ld[0]});
    check_eq("load2", {15'd0, lp2}, {15'd0, exp_ld[1]});
    if (lp2) begin
      lp2_prev = lp2_last;
      lp2_last = cyc;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k, r, d, pe);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    sbits[0] = 1; sbits[1] = 2;
    mlen[0] = 0; mlen[1] = 0;
    exp_ld[0] = 1'b0; exp_ld[1] = 1'b0;
    hist_tx1 = '0; hist_busy1 = '0;
    lp2_prev = 0; lp2_last = 0;
    reset = 1'b1; data_valid = 1'b0; p_data = 8'h00; par_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state, and no strobe while reset is high even with a request pending.
    cycle(1'b1, 1'b1, 8'h5A, 1'b1);
    cycle(1'b1, 1'b1, 8'hC3, 1'b0);

    // 0xA5 with even parity, single-cycle request.
    cycle(1'b0, 1'b1, 8'hA5, 1'b1);
    idle_cycles(11);
    check_eq("a5_frame", {5'd0, hist_tx1[10:0]}, 16'b0000_0010_1001_0101);
    check_eq("a5_busy", {5'd0, hist_busy1[10:0]}, 16'h07FF);
    check_eq("a5_after_tx", {15'd0, tx1}, 16'd1);
    check_eq("a5_after_busy", {15'd0, busy1}, 16'd0);
    idle_cycles(3);

    // 0x01 without parity; PAR_bit forced opposite to show it is unused.
    cycle(1'b0, 1'b1, 8'h01, 1'b0);
    par_bit1 = 1'b1;
    idle_cycles(10);
    check_eq("x01_frame", {6'd0, hist_tx1[9:0]}, 16'b0000_0001_0000_0001);
    idle_cycles(3);

    // Continuous request: 0xFF then 0x00 back to back.
    cycle(1'b0, 1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 25; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
    check_eq("b2b_gap2", lp2_last[15:0] - lp2_prev[15:0], 16'd11);
    idle_cycles(14);

    // Request during data bits of an in-flight frame must be dropped.
    cycle(1'b0, 1'b1, 8'hA5, 1'b1);
    idle_cycles(3);
    cycle(1'b0, 1'b1, 8'h3C, 1'b0);
    cycle(1'b0, 1'b1, 8'h3C, 1'b1);
    idle_cycles(14);

    // Reset on data bit 4, then a fresh 0x55 frame.
    cycle(1'b0, 1'b1, 8'hA5, 1'b1);
    idle_cycles(5);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    check_eq("rst_tx1", {15'd0, tx1}, 16'd1);
    check_eq("rst_busy1", {15'd0, busy1}, 16'd0);
    check_eq("rst_state", {13'd0, dut1.state}, 16'd0);
    cycle(1'b0, 1'b1, 8'h55, 1'b1);
    idle_cycles(14);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
            8'($urandom), 1'($urandom));
    end
    idle_cycles(14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame_ctrl.md
UART_TX_FRAME_CTRL -- requirements
Module: uart_tx_frame_ctrl

Interface
REQ-001 SHALL have parameter STOP_BITS, default 1, number of stop bits per frame; legal values are 1 and 2 only.
REQ-002 SHALL have port clk  input  1  transmit bit clock; one serial bit per cycle.
REQ-003 SHALL have port reset  input  1  synchronous reset, active-high.
REQ-004 SHALL have port P_DATA  input  8  parallel byte to transmit, sampled on the accept cycle.
REQ-005 SHALL have port Data_Valid  input  1  upstream request to send P_DATA.
REQ-006 SHALL have port PAR_EN  input  1  parity bit inserted when 1, sampled on the accept cycle.
REQ-007 SHALL have port PAR_bit  input  1  parity bit from the parity calculator, registered by that stage on the accept edge.
REQ-008 SHALL have port Load_Pulse  output  1  combinational accept strobe that drives the parity calculator's Data_Valid.
REQ-009 SHALL have port TX_OUT  output  1  registered serial line; idle level is 1.
REQ-010 SHALL have port Busy  output  1  registered; high while a frame is in progress.

Function
REQ-011 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-012 SHALL define can_accept as (state==IDLE) or (state==STOP and the final stop bit is on the line).
REQ-013 SHALL compute Load_Pulse = Data_Valid & can_accept, with no registering.
REQ-014 SHALL, on an accept edge, latch P_DATA into an 8-bit shift register, latch PAR_EN, and go to START.
REQ-015 SHALL drive TX_OUT=0 in START for exactly 1 cycle and then go to DATA.
REQ-016 SHALL drive in DATA the shift register LSB-first for 8 cycles, tracked by a 3-bit bit counter, with the exit on count 7.
REQ-017 SHALL leave DATA for PARITY when the latched PAR_EN=1, and for STOP otherwise.
REQ-018 SHALL drive TX_OUT=PAR_bit in PARITY for exactly 1 cycle, sampled directly with no local copy, and then go to STOP.
REQ-019 SHALL drive TX_OUT=1 in STOP for STOP_BITS cycles.
REQ-020 SHALL leave STOP after the final stop cycle for START if Load_Pulse=1 (back-to-back frame, no idle gap), and for IDLE otherwise.
REQ-021 SHALL hold TX_OUT=1 in IDLE.
REQ-022 SHALL ignore Data_Valid whenever can_accept=0: Load_Pulse=0, P_DATA is not sampled, and the frame in progress is undisturbed.
REQ-023 SHALL ignore changes on P_DATA and PAR_EN after the accept edge until the next accept.
REQ-024 SHALL make TX_OUT, Busy and state all registers updated on the same edge, with TX_OUT reflecting the current state's bit.
REQ-025 SHALL hold Busy=1 in START, DATA, PARITY and STOP, and Busy=0 only in IDLE.
REQ-026 SHALL set the latency from the accept edge to the start bit on TX_OUT to 1 cycle, i.e. TX_OUT=0 in the cycle following the Load_Pulse cycle.
REQ-027 SHALL set the frame length to 1+8+PAR_EN+STOP_BITS cycles.

Reset
REQ-028 SHALL, when reset=1 at a clk edge, set state=IDLE, TX_OUT=1, Busy=0, shift register=0, bit counter=0 and latched PAR_EN=0.
REQ-029 SHALL hold Load_Pulse=0 while reset=1 regardless of Data_Valid.
REQ-030 SHALL abort any frame on a reset mid-frame, with TX_OUT=1 from the next cycle and no stale bits afterwards.
REQ-031 SHALL accept a new request after reset deasserts only from IDLE.

Verification
REQ-032 SHALL cover: P_DATA=0xA5, PAR_EN=1, PAR_bit=0 (even), STOP_BITS=1, one-cycle Data_Valid -> Load_Pulse=1 for 1 cycle; TX_OUT over 11 cycles = 0,1,0,1,0,0,1,0,1,0,1; Busy high for 11 cycles, then TX_OUT=1 and Busy=0.
REQ-033 SHALL cover: P_DATA=0x01, PAR_EN=0 -> TX_OUT = 0,1,0,0,0,0,0,0,0,1 over 10 cycles; the PAR_bit value has no effect.
REQ-034 SHALL cover: STOP_BITS=2 and Data_Valid held high continuously with 0xFF then 0x00, PAR_EN=0 -> frames of 11 cycles with no idle gap; the second start bit immediately follows the second stop bit; Load_Pulse=1 only in IDLE and final-stop cycles.
REQ-035 SHALL cover: Data_Valid pulsed with 0x3C during the DATA bits of a 0xA5 frame -> Load_Pulse=0, the 0xA5 frame is transmitted intact, and 0x3C is never sent.
REQ-036 SHALL cover: reset=1 asserted at data bit 4 of a frame -> the next cycle has TX_OUT=1, Busy=0 and state=IDLE; a fresh request for 0x55 then produces a correct full frame.
